// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the IF/ID register slice.
//   NOP_INS    instruction pattern used for squashed / reset lanes
//   IW_DEF     default instruction width
//   PCW_DEF    default PC+4 width (word address, PC[31:2])
//   lane_rec_t per-lane {valid, ins, pc4} record at the default widths
package pipe_pkg;

    localparam int          IW_DEF  = 32;
    localparam int          PCW_DEF = 30;
    localparam logic [31:0] NOP_INS = 32'd0;

    typedef struct packed {
        logic               valid;
        logic [IW_DEF-1:0]  ins;
        logic [PCW_DEF-1:0] pc4;
    } lane_rec_t;

endpackage

// File: rtl/if_id_multi_if.sv
// Bus between the fetch/control side and the IF/ID register.
//   master: drives flush, stall, bubble_hold, kill_mask, if_valid, if_ins, if_pc4;
//           observes the registered id_* group, id_held and the counters.
//   slave : the register itself (the opposite directions).
interface if_id_multi_if #(
    parameter int LANES = 2,
    parameter int IW    = 32,
    parameter int PCW   = 30,
    parameter int CNT_W = 16
);
    logic                   flush;
    logic                   stall;
    logic                   bubble_hold;
    logic [LANES-1:0]       kill_mask;
    logic [LANES-1:0]       if_valid;
    logic [LANES*IW-1:0]    if_ins;
    logic [LANES*PCW-1:0]   if_pc4;

    logic [LANES-1:0]       id_valid;
    logic [LANES*IW-1:0]    id_ins;
    logic [LANES*PCW-1:0]   id_pc4;
    logic                   id_held;
    logic [CNT_W-1:0]       stall_cnt;
    logic [CNT_W-1:0]       flush_cnt;

    modport master (
        output flush, stall, bubble_hold, kill_mask, if_valid, if_ins, if_pc4,
        input  id_valid, id_ins, id_pc4, id_held, stall_cnt, flush_cnt
    );

    modport slave (
        input  flush, stall, bubble_hold, kill_mask, if_valid, if_ins, if_pc4,
        output id_valid, id_ins, id_pc4, id_held, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/if_id_lane.sv
// One lane of the IF/ID register.
//   Clk, Reset         clock and synchronous active-high reset
//   ctl_flush          squash this lane (PC still captured)
//   ctl_hold           keep current contents (only seen when ctl_flush is low)
//   kill, in_valid     per-lane squash / fetch-valid for a normal load
//   in_ins, in_pc4     fetched instruction and its PC+4
//   out_valid/ins/pc4  registered lane contents
module if_id_lane
    import pipe_pkg::*;
#(
    parameter int             IW        = IW_DEF,
    parameter int             PCW       = PCW_DEF,
    parameter logic [IW-1:0]  NOP_VALUE = IW'(NOP_INS)
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            ctl_flush,
    input  logic            ctl_hold,
    input  logic            kill,
    input  logic            in_valid,
    input  logic [IW-1:0]   in_ins,
    input  logic [PCW-1:0]  in_pc4,
    output logic            out_valid,
    output logic [IW-1:0]   out_ins,
    output logic [PCW-1:0]  out_pc4
);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            out_valid <= 1'b0;
            out_ins   <= NOP_VALUE;
            out_pc4   <= '0;
        end else if (ctl_flush || (!ctl_hold && (kill || !in_valid))) begin
            // Squashed slot: PC is kept for link/exception use.
            out_valid <= 1'b0;
            out_ins   <= NOP_VALUE;
            out_pc4   <= in_pc4;
        end else if (!ctl_hold) begin
            out_valid <= 1'b1;
            out_ins   <= in_ins;
            out_pc4   <= in_pc4;
        end
    end

endmodule

// File: rtl/if_id_multi.sv
// LANES-wide IF/ID pipeline register between fetch and decode.
//   Clk, Reset  clock and synchronous active-high reset
//   bus (slave) control inputs flush/stall/bubble_hold/kill_mask, fetch group
//               if_valid/if_ins/if_pc4; registered id_valid/id_ins/id_pc4,
//               id_held and saturating stall_cnt/flush_cnt debug counters.
// Edge priority: Reset > flush > (stall | bubble_hold) > load.
module if_id_multi
    import pipe_pkg::*;
#(
    parameter int             LANES     = 2,
    parameter int             IW        = IW_DEF,
    parameter int             PCW       = PCW_DEF,
    parameter logic [IW-1:0]  NOP_VALUE = IW'(NOP_INS),
    parameter int             CNT_W     = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    if_id_multi_if.slave    bus
);

    logic                   hold;
    logic [LANES-1:0]       lane_valid;
    logic [LANES*IW-1:0]    lane_ins;
    logic [LANES*PCW-1:0]   lane_pc4;
    logic                   held_q;
    logic [CNT_W-1:0]       stall_cnt_q;
    logic [CNT_W-1:0]       flush_cnt_q;

    // Flush dominates; a hold is only effective when no flush is present.
    assign hold = (bus.stall || bus.bubble_hold) && !bus.flush;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        if_id_lane #(
            .IW        (IW),
            .PCW       (PCW),
            .NOP_VALUE (NOP_VALUE)
        ) u_lane (
            .Clk       (Clk),
            .Reset     (Reset),
            .ctl_flush (bus.flush),
            .ctl_hold  (hold),
            .kill      (bus.kill_mask[i]),
            .in_valid  (bus.if_valid[i]),
            .in_ins    (bus.if_ins[i*IW +: IW]),
            .in_pc4    (bus.if_pc4[i*PCW +: PCW]),
            .out_valid (lane_valid[i]),
            .out_ins   (lane_ins[i*IW +: IW]),
            .out_pc4   (lane_pc4[i*PCW +: PCW])
        );
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            held_q      <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            held_q <= hold;
            if (bus.flush && flush_cnt_q != '1)
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            if (hold && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign bus.id_valid  = lane_valid;
    assign bus.id_ins    = lane_ins;
    assign bus.id_pc4    = lane_pc4;
    assign bus.id_held   = held_q;
    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_if_id_multi.sv
module tb_if_id_multi;
    import pipe_pkg::*;

    localparam int LANES = 2;
    localparam int IW    = 32;
    localparam int PCW   = 30;
    localparam int CNT_W = 4;

    logic Clk;
    logic Reset;
    int   n_vec;
    int   n_err;

    if_id_multi_if #(.LANES(LANES), .IW(IW), .PCW(PCW), .CNT_W(CNT_W)) bus ();

    if_id_multi #(
        .LANES (LANES),
        .IW    (IW),
        .PCW   (PCW),
        .CNT_W (CNT_W)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic st, input logic bh,
                         input logic [1:0] km, input logic [1:0] vl,
                         input logic [63:0] ins, input logic [59:0] pc4);
        bus.flush       = fl;
        bus.stall       = st;
        bus.bubble_hold = bh;
        bus.kill_mask   = km;
        bus.if_valid    = vl;
        bus.if_ins      = ins;
        bus.if_pc4      = pc4;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_group(input string tag, input lane_rec_t l1, input lane_rec_t l0);
        chk({tag, ".valid"}, 64'(bus.id_valid), 64'({l1.valid, l0.valid}));
        chk({tag, ".ins"},   64'(bus.id_ins),   {l1.ins, l0.ins});
        chk({tag, ".pc4"},   64'(bus.id_pc4),   64'({l1.pc4, l0.pc4}));
    endtask

    lane_rec_t pre1, pre0;
    int        exp_stall;
    int        exp_flush;

    initial begin
        n_vec = 0;
        n_err = 0;

        // Reset with random inputs on the bus.
        Reset = 1'b1;
        drive(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
              {$urandom, $urandom}, 60'({$urandom, $urandom}));
        tick();
        drive(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom),
              {$urandom, $urandom}, 60'({$urandom, $urandom}));
        tick();
        chk_group("reset", '{1'b0, 32'h0, 30'h0}, '{1'b0, 32'h0, 30'h0});
        chk("reset.held",  64'(bus.id_held),   64'd0);
        chk("reset.scnt",  64'(bus.stall_cnt), 64'd0);
        chk("reset.fcnt",  64'(bus.flush_cnt), 64'd0);

        // Normal load.
        Reset = 1'b0;
        drive(0, 0, 0, 2'b00, 2'b11, {32'h8C220004, 32'h00430820}, {30'h1, 30'h2});
        tick();
        pre1 = '{1'b1, 32'h8C220004, 30'h1};
        pre0 = '{1'b1, 32'h00430820, 30'h2};
        chk_group("load", pre1, pre0);
        chk("load.held", 64'(bus.id_held), 64'd0);

        // Three hold edges: stall, bubble_hold, both; inputs and kill_mask churn.
        for (int k = 1; k <= 3; k++) begin
            drive(0, k != 2, k != 1, 2'b11, 2'b11,
                  {32'hDEAD0000 + 32'(k), 32'hBEEF0000 + 32'(k)}, {30'h100 + 30'(k), 30'h200 + 30'(k)});
            tick();
            chk_group("hold", pre1, pre0);
            chk("hold.held", 64'(bus.id_held),   64'd1);
            chk("hold.scnt", 64'(bus.stall_cnt), 64'(k));
        end

        // Release: lane1 not valid, so it loads a NOP with its PC.
        drive(0, 0, 0, 2'b00, 2'b01, {32'h11111111, 32'h22222222}, {30'h5, 30'h6});
        tick();
        chk_group("release", '{1'b0, 32'h0, 30'h5}, '{1'b1, 32'h22222222, 30'h6});
        chk("release.held", 64'(bus.id_held),   64'd0);
        chk("release.scnt", 64'(bus.stall_cnt), 64'd3);

        // Flush with stall also high.
        drive(1, 1, 0, 2'b00, 2'b11, {32'h33333333, 32'h44444444}, {30'h10, 30'h11});
        tick();
        chk_group("flush", '{1'b0, 32'h0, 30'h10}, '{1'b0, 32'h0, 30'h11});
        chk("flush.held", 64'(bus.id_held),   64'd0);
        chk("flush.fcnt", 64'(bus.flush_cnt), 64'd1);
        chk("flush.scnt", 64'(bus.stall_cnt), 64'd3);

        // Partial squash of lane1.
        drive(0, 0, 0, 2'b10, 2'b11, {32'hAAAA5555, 32'h12345678}, {30'h20, 30'h21});
        tick();
        chk_group("squash", '{1'b0, 32'h0, 30'h20}, '{1'b1, 32'h12345678, 30'h21});

        // Stall counter saturation over 20 hold edges.
        exp_stall = 3;
        for (int k = 0; k < 20; k++) begin
            drive(0, 0, 1, 2'b00, 2'b11, {32'h0F0F0F0F, 32'hF0F0F0F0}, {30'h30, 30'h31});
            tick();
            exp_stall = (exp_stall < 15) ? exp_stall + 1 : 15;
            chk("sat.scnt", 64'(bus.stall_cnt), 64'(exp_stall));
        end
        chk_group("sat.frozen", '{1'b0, 32'h0, 30'h20}, '{1'b1, 32'h12345678, 30'h21});

        // Flush counter saturation.
        exp_flush = 1;
        for (int k = 0; k < 16; k++) begin
            drive(1, 0, 0, 2'b00, 2'b11, {32'h1, 32'h2}, {30'h40, 30'h41});
            tick();
            exp_flush = (exp_flush < 15) ? exp_flush + 1 : 15;
            chk("fsat.fcnt", 64'(bus.flush_cnt), 64'(exp_flush));
        end
        chk("fsat.scnt", 64'(bus.stall_cnt), 64'd15);

        // Load a group, then hold and assert Reset during the hold.
        drive(0, 0, 0, 2'b00, 2'b11, {32'hCAFEBABE, 32'h01234567}, {30'h50, 30'h51});
        tick();
        drive(0, 1, 0, 2'b00, 2'b11, {32'h9, 32'h8}, {30'h60, 30'h61});
        tick();
        chk("prerst.held", 64'(bus.id_held), 64'd1);
        Reset = 1'b1;
        tick();
        chk_group("rsthold", '{1'b0, 32'h0, 30'h0}, '{1'b0, 32'h0, 30'h0});
        chk("rsthold.scnt", 64'(bus.stall_cnt), 64'd0);
        chk("rsthold.fcnt", 64'(bus.flush_cnt), 64'd0);
        chk("rsthold.held", 64'(bus.id_held),   64'd0);

        // Next non-reset edge with stall still high follows normal priority.
        Reset = 1'b0;
        tick();
        chk("posthold.held", 64'(bus.id_held),   64'd1);
        chk("posthold.scnt", 64'(bus.stall_cnt), 64'd1);
        chk_group("posthold", '{1'b0, 32'h0, 30'h0}, '{1'b0, 32'h0, 30'h0});

        // Reset during a flush, then a flush edge counts from zero.
        drive(1, 0, 0, 2'b00, 2'b11, {32'h7, 32'h6}, {30'h70, 30'h71});
        Reset = 1'b1;
        tick();
        chk("rstflush.fcnt", 64'(bus.flush_cnt), 64'd0);
        chk("rstflush.pc4",  64'(bus.id_pc4),    64'd0);
        Reset = 1'b0;
        tick();
        chk("postflush.fcnt", 64'(bus.flush_cnt), 64'd1);
        chk("postflush.pc4",  64'(bus.id_pc4),    64'({30'h70, 30'h71}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
